keccak_squeeze_reader: RTL and testbench

Consumer on the squeeze side of the Dilithium Keccak permutation core. It captures the permuted 1600-bit state when the core raises its out-ready flag and serialises the rate portion as 64-bit lanes over a valid/ready stream. When a block's rate is exhausted and more output is still owed, it pulses the core's squeeze input for the next permutation. It feeds SHAKE128 (matrix expansion) and SHAKE256 (sampling) consumers with an exact, caller-specified word count.

---
 rtl/keccak_squeeze_reader.sv | 137 +++++++++++++
 tb/tb_keccak_squeeze_reader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_squeeze_reader.sv
// Squeeze-side reader for the Keccak permutation core: captures the rate part of
// each permuted state and streams it lane by lane, requesting more permutations as needed.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no session; start latches mode and word count
// WAIT  | waiting for the core's out-ready to capture a fresh state
// EMIT  | presenting buffer lane idx on the output stream
// SQZ   | squeeze issued; waiting for out-ready to drop before re-arming
module keccak_squeeze_reader #(
    parameter int LANE_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic [CNT_W-1:0]  req_words,
    input  logic [1599:0]     perm_out,
    input  logic              perm_out_ready,
    output logic              squeeze,
    output logic [LANE_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done
);

    localparam int RATE_BITS = 1344;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_EMIT,
        ST_SQZ
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [RATE_BITS-1:0]   buffer;
    logic [4:0]             idx;
    logic [4:0]             rate_last;
    logic [CNT_W-1:0]       remaining;
    logic                   hs;
    logic                   load;
    logic                   capture;
    logic                   squeeze_nxt;
    logic                   done_nxt;
    logic                   unused_capacity;

    // Capacity lanes never leave the block.
    assign unused_capacity = ^perm_out[1599:RATE_BITS];

    assign hs         = (state == ST_EMIT) && dout_ready;
    assign dout_valid = (state == ST_EMIT);
    assign busy       = (state != ST_IDLE);
    assign dout       = dout_valid ? buffer[{idx, 6'b0} +: LANE_W] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        capture     = 1'b0;
        squeeze_nxt = 1'b0;
        done_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (req_words == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (perm_out_ready) begin
                    capture   = 1'b1;
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (dout_ready) begin
                    // Final word wins over end-of-rate: no trailing squeeze.
                    if (remaining == CNT_W'(1)) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else if (idx == rate_last) begin
                        state_nxt   = ST_SQZ;
                        squeeze_nxt = 1'b1;
                    end
                end
            end
            ST_SQZ: begin
                if (!perm_out_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buffer    <= '0;
            idx       <= '0;
            rate_last <= '0;
            remaining <= '0;
            squeeze   <= 1'b0;
            done      <= 1'b0;
        end else begin
            squeeze <= squeeze_nxt;
            done    <= done_nxt;
            if (load) begin
                rate_last <= (mode == 2'b00) ? 5'd20 : 5'd16;
                remaining <= req_words;
            end
            if (capture) begin
                buffer <= perm_out[RATE_BITS-1:0];
                idx    <= '0;
            end
            if (hs) begin
                remaining <= remaining - CNT_W'(1);
                idx       <= idx + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_keccak_squeeze_reader.sv
// Bench for keccak_squeeze_reader: behavioural core responder, stream monitor and
// a word-list reference model built from random permutation states.
module tb_keccak_squeeze_reader;

    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        mode;
    logic              start;
    logic [CNT_W-1:0]  req_words;
    logic [1599:0]     perm_out = '0;
    logic              perm_out_ready = 1'b0;
    logic              squeeze;
    logic [63:0]       dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    keccak_squeeze_reader #(.LANE_W(64), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .mode           (mode),
        .start          (start),
        .req_words      (req_words),
        .perm_out       (perm_out),
        .perm_out_ready (perm_out_ready),
        .squeeze        (squeeze),
        .dout           (dout),
        .dout_valid     (dout_valid),
        .dout_ready     (dout_ready),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Permutation core model: states are handed out in order from blocks[].
    logic [1599:0] blocks [0:255];
    int blk_wr = 0;
    int blk_rd = 0;
    int kick_n = 0;
    int kick_seen = 0;
    int lat = 0;
    int drop_dly = 0;
    int rise_cnt = -1;
    int drop_cnt = -1;
    int sqz_count = 0;

    always @(posedge clk) begin
        #1;
        if (rise_cnt == 0) begin
            if (blk_rd < blk_wr) begin
                perm_out = blocks[blk_rd % 256];
                blk_rd++;
            end
            perm_out_ready = 1'b1;
            rise_cnt = -1;
        end else if (rise_cnt > 0) begin
            rise_cnt--;
        end
        if (kick_n != kick_seen) begin
            kick_seen = kick_n;
            perm_out_ready = 1'b0;
            rise_cnt = lat;
        end
        if (squeeze) begin
            sqz_count++;
            drop_cnt = drop_dly;
        end
        if (drop_cnt == 0) begin
            perm_out_ready = 1'b0;
            drop_cnt = -1;
            rise_cnt = lat;
        end else if (drop_cnt > 0) begin
            drop_cnt--;
        end
    end

    // Stream monitor: values seen at negedge are those present at the next posedge.
    logic [63:0] got [0:4095];
    int got_n = 0;
    int done_n = 0;
    logic prev_stall = 1'b0;
    logic prev_sqz = 1'b0;
    logic [63:0] prev_dout = '0;

    always @(negedge clk) begin
        if (reset) begin
            if (prev_stall) begin
                check("hold_valid", dout_valid, 1'b1);
                check("hold_data", dout, prev_dout);
            end
            if (dout_valid && dout_ready) begin
                got[got_n % 4096] = dout;
                got_n++;
            end
            if (done) done_n++;
            if (squeeze) check("sqz_single_cycle", prev_sqz, 1'b0);
        end
        prev_stall = reset && dout_valid && !dout_ready;
        prev_dout  = dout;
        prev_sqz   = reset && squeeze;
    end

    logic [1599:0] last_blk = '0;

    task automatic run_session(input logic [1:0] m, input int n, input bit bp, input int hold_after,
                               input bit fresh, input bit poke, input int abort_at);
        int rate, nb, base, dbase, sbase, t, prev_got;
        logic [63:0] exp_q [$];
        logic [1599:0] blk;
        bit held;
        rate = (m == 2'b00) ? 21 : 17;
        nb = (n + rate - 1) / rate;
        lat = $urandom_range(0, 3);
        drop_dly = $urandom_range(0, 2);
        for (int b = 0; b < nb; b++) begin
            if (b == 0 && !fresh) begin
                blk = last_blk;
            end else begin
                for (int l = 0; l < 25; l++) blk[64*l +: 64] = {$urandom, $urandom};
                blocks[blk_wr % 256] = blk;
                blk_wr++;
            end
            for (int l = 0; l < rate; l++)
                if (exp_q.size() < n) exp_q.push_back(blk[64*l +: 64]);
            last_blk = blk;
        end
        if (fresh && n > 0) kick_n++;
        repeat (2) begin @(posedge clk); #1; end
        base = got_n; dbase = done_n; sbase = sqz_count;
        mode = m; req_words = CNT_W'(n); start = 1'b1; dout_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, (n == 0) ? 1'b0 : 1'b1);
        t = 0; held = 0; prev_got = base;
        while (!done && t < 4000) begin
            if (poke && t == 3) begin
                start = 1'b1; req_words = CNT_W'(7); mode = ~m;
            end else begin
                start = 1'b0;
            end
            if (abort_at >= 0 && got_n - base == abort_at) begin
                reset = 1'b0;
                #1;
                check("rst_squeeze", squeeze, 1'b0);
                check("rst_valid", dout_valid, 1'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_done", done, 1'b0);
                check("rst_dout", dout, 64'd0);
                @(posedge clk); #1;
                reset = 1'b1;
                return;
            end
            if (hold_after >= 0 && !held && got_n - base == hold_after) begin
                held = 1;
                dout_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                    check("bp_valid", dout_valid, 1'b1);
                    check("bp_dout", dout, exp_q[hold_after]);
                end
            end
            dout_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            prev_got = got_n;
            @(posedge clk); #1;
            t++;
        end
        start = 1'b0;
        check("timeout", (t < 4000) ? 1'b1 : 1'b0, 1'b1);
        if (n > 0) check("done_follows_last_word", (got_n != prev_got) ? 1'b1 : 1'b0, 1'b1);
        check("word_count", 64'(got_n - base), 64'(n));
        for (int i = 0; i < n && i < got_n - base; i++)
            check($sformatf("word%0d", i), got[(base + i) % 4096], exp_q[i]);
        check("squeeze_count", 64'(sqz_count - sbase), 64'((nb > 0) ? nb - 1 : 0));
        @(posedge clk); #1;
        check("done_pulse_end", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_valid", dout_valid, 1'b0);
        check("done_count", 64'(done_n - dbase), 64'd1);
        dout_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; mode = 2'b00; req_words = '0; dout_ready = 1'b0;
        #3;
        check("reset_squeeze", squeeze, 1'b0);
        check("reset_valid", dout_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_dout", dout, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        run_session(2'b00, 3, 0, -1, 1, 0, -1);
        run_session(2'b00, 25, 0, -1, 1, 0, -1);
        run_session(2'b10, 17, 0, -1, 1, 0, -1);
        run_session(2'b10, 18, 0, -1, 1, 0, -1);
        run_session(2'b00, 21, 0, -1, 1, 0, -1);
        run_session(2'b00, 5, 0, 2, 1, 0, -1);
        run_session(2'b00, 0, 0, -1, 1, 0, -1);
        run_session(2'b00, 30, 0, -1, 1, 1, -1);
        run_session(2'b00, 21, 0, -1, 1, 0, 7);
        run_session(2'b00, 2, 0, -1, 0, 0, -1);
        for (int s = 0; s < 12; s++)
            run_session(2'($urandom_range(0, 3)), $urandom_range(1, 60), 1'($urandom_range(0, 1)),
                        -1, 1, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
